// File: rtl/usb_pkg.sv
// Shared USB serial-path definitions: stuffer state encoding and default widths.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        EOP    = 2'd2
    } stuff_state_t;

    localparam int unsigned USB_STUFF_LEN = 6;
    localparam int unsigned STUFF_CNT_W   = 8;

endpackage

// File: rtl/bit_stuffer_counter.sv
// Generic up-counter with clear; clear and increment together load the value 1.
module counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_L,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bit_stuffer.sv
// Bit stuffer: inserts a 0 after STUFF_LEN consecutive 1s, back-pressures the
// encoder through pause, and closes each packet with a 2-cycle EOP marker.
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int unsigned STUFF_LEN = USB_STUFF_LEN
) (
    input  logic                   clk,
    input  logic                   rst_L,
    input  logic                   in_bit,
    input  logic                   in_sending,
    output logic                   pause,
    output logic                   out_bit,
    output logic                   out_valid,
    output logic                   out_eop,
    output logic [STUFF_CNT_W-1:0] stuff_cnt
);

    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

    stuff_state_t      state;
    logic              eop_cnt;
    logic [ONES_W-1:0] ones_cnt;
    logic              stuff_pend;
    logic              cnt_inc;
    logic              cnt_clr;

    assign stuff_pend = (ones_cnt == ONES_W'(STUFF_LEN));
    assign pause      = stuff_pend || (state == EOP);

    counter #(.W(ONES_W)) u_ones_cnt (
        .clk   (clk),
        .rst_L (rst_L),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (ones_cnt)
    );

    // ones_cnt is always 0 in IDLE, so clear+inc there loads in_bit directly.
    always_comb begin
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state)
            IDLE: begin
                if (in_sending) begin
                    cnt_clr = 1'b1;
                    cnt_inc = in_bit;
                end
            end
            ACTIVE: begin
                if (stuff_pend) begin
                    cnt_clr = 1'b1;
                end else if (in_sending) begin
                    cnt_inc = in_bit;
                    cnt_clr = !in_bit;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            eop_cnt   <= 1'b0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_eop   <= 1'b0;
            stuff_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_sending) begin
                        out_bit   <= in_bit;
                        out_valid <= 1'b1;
                        stuff_cnt <= '0;
                        state     <= ACTIVE;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (stuff_pend) begin
                        out_bit   <= 1'b0;
                        out_valid <= 1'b1;
                        if (stuff_cnt != '1) begin
                            stuff_cnt <= stuff_cnt + 1'b1;
                        end
                    end else if (in_sending) begin
                        out_bit   <= in_bit;
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                        out_eop   <= 1'b1;
                        eop_cnt   <= 1'b0;
                        state     <= EOP;
                    end
                end
                EOP: begin
                    out_valid <= 1'b0;
                    if (!eop_cnt) begin
                        eop_cnt <= 1'b1;
                    end else begin
                        out_eop <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_stuffer.sv
// Self-checking bench for bit_stuffer: an encoder model honouring pause feeds
// packets; outputs are compared against a stream-level stuffing model.
module tb_bit_stuffer;

    localparam int unsigned SL = 6;

    logic       clk;
    logic       rst_L;
    logic       in_bit;
    logic       in_sending;
    logic       pause;
    logic       out_bit;
    logic       out_valid;
    logic       out_eop;
    logic [7:0] stuff_cnt;

    int checks   = 0;
    int failures = 0;

    bit pq[$];
    bit exp_q[$];
    bit got_q[$];
    int exp_stuffs;
    int exp_first_stuff;

    bit_stuffer #(.STUFF_LEN(SL)) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .in_bit     (in_bit),
        .in_sending (in_sending),
        .pause      (pause),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .out_eop    (out_eop),
        .stuff_cnt  (stuff_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the payload, append a 0 after every SL-long run of 1s.
    task automatic model();
        int ones;
        exp_q.delete();
        ones            = 0;
        exp_stuffs      = 0;
        exp_first_stuff = -1;
        foreach (pq[i]) begin
            exp_q.push_back(pq[i]);
            ones = pq[i] ? ones + 1 : 0;
            if (ones == SL) begin
                exp_q.push_back(1'b0);
                exp_stuffs++;
                if (exp_first_stuff < 0) exp_first_stuff = i;
                ones = 0;
            end
        end
    endtask

    task automatic set_bits(input int n, input bit v);
        for (int i = 0; i < n; i++) pq.push_back(v);
    endtask

    task automatic run_packet(input string name);
        int idx, first_valid, first_pause, eop_cycles, eop_pause, pause_cycles, budget, mism;
        bit eop_seen, valid_after_eop, done;
        model();
        got_q.delete();
        idx = 0; first_valid = -1; first_pause = -1;
        eop_cycles = 0; eop_pause = 0; pause_cycles = 0;
        eop_seen = 0; valid_after_eop = 0; done = 0;
        budget = pq.size() * 2 + 20;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got_q.push_back(out_bit);
                if (first_valid < 0) first_valid = c;
                if (eop_seen) valid_after_eop = 1;
            end
            if (out_eop) begin
                eop_cycles++;
                eop_seen = 1;
                if (pause) eop_pause++;
            end else if (eop_seen) begin
                done = 1;
            end
            if (pause) begin
                pause_cycles++;
                if (first_pause < 0) first_pause = c;
            end
            if (idx < pq.size()) begin
                in_sending = 1'b1;
                in_bit     = pq[idx];
                if (!pause) idx++;
            end else begin
                in_sending = 1'b0;
                in_bit     = 1'b0;
            end
        end
        chk({name, ":finished"}, done, 1);
        chk({name, ":stream_len"}, got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
        chk({name, ":stream_bit_errors"}, mism, 0);
        chk({name, ":first_valid_cycle"}, first_valid, 1);
        if (exp_stuffs > 0) chk({name, ":first_pause_cycle"}, first_pause, exp_first_stuff + 1);
        chk({name, ":eop_cycles"}, eop_cycles, 2);
        chk({name, ":pause_during_eop"}, eop_pause, 2);
        chk({name, ":pause_cycles"}, pause_cycles, exp_stuffs + 2);
        chk({name, ":valid_after_eop"}, valid_after_eop, 0);
        chk({name, ":stuff_cnt"}, stuff_cnt, (exp_stuffs > 255) ? 255 : exp_stuffs);
    endtask

    initial begin
        int pauses;
        bit found;
        rst_L      = 1'b0;
        in_bit     = 1'b0;
        in_sending = 1'b0;
        #12;
        chk("reset:out_bit",   out_bit,   0);
        chk("reset:out_valid", out_valid, 0);
        chk("reset:out_eop",   out_eop,   0);
        chk("reset:pause",     pause,     0);
        chk("reset:stuff_cnt", stuff_cnt, 0);
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);

        pq.delete(); set_bits(8, 1'b0);  run_packet("no_ones");
        pq.delete(); set_bits(7, 1'b1);  run_packet("one_stuff");
        pq.delete(); set_bits(12, 1'b1); run_packet("two_stuffs");
        pq.delete(); set_bits(5, 1'b1); set_bits(1, 1'b0); set_bits(5, 1'b1);
        run_packet("zero_resets_run");
        pq.delete(); set_bits(6, 1'b1);  run_packet("stuff_at_end");
        pq.delete(); set_bits(1536, 1'b1); run_packet("saturate");

        // Reset asserted on the second stuff of a packet of 12 ones.
        pq.delete(); set_bits(12, 1'b1);
        pauses = 0; found = 0;
        for (int c = 0, idx = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (pause) pauses++;
            if (pause && pauses == 2) begin
                found = 1;
            end else begin
                in_sending = (idx < pq.size());
                in_bit     = (idx < pq.size()) ? pq[idx] : 1'b0;
                if (!pause && idx < pq.size()) idx++;
            end
        end
        chk("rst_mid:found_second_pause", found, 1);
        chk("rst_mid:pre_stuff_cnt", stuff_cnt, 1);
        rst_L = 1'b0;
        #1;
        chk("rst_mid:pause",     pause,     0);
        chk("rst_mid:out_valid", out_valid, 0);
        chk("rst_mid:out_eop",   out_eop,   0);
        chk("rst_mid:stuff_cnt", stuff_cnt, 0);
        in_sending = 1'b0;
        in_bit     = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        pq.delete(); set_bits(3, 1'b0); set_bits(7, 1'b1); run_packet("after_reset");

        for (int p = 0; p < 20; p++) begin
            int len;
            pq.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) pq.push_back(($urandom % 5) != 0);
            run_packet($sformatf("rand%0d", p));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_stuffer.md
# bit_stuffer

Serial bit-stuffing stage placed directly downstream of `bitstream_encoder`. It takes the encoder's serial `outb`/`sending` stream and inserts a 0 after every `STUFF_LEN` consecutive 1s. While it inserts, it drives `pause` back to the encoder so no payload bit is lost. At the end of each packet it emits a 2-cycle end-of-packet marker. Its output feeds the NRZI/line-driver stage.

## Interface
- `STUFF_LEN`, default 6: number of consecutive 1s that triggers insertion of one 0.
- `clk`  in  1  clock.
- `rst_L`  in  1  reset, asynchronous, active-low.
- `in_bit`  in  1  serial data bit from the encoder (`outb`).
- `in_sending`  in  1  encoder `sending`; `in_bit` is valid when high.
- `pause`  out  1  to encoder `pause`; while high the encoder holds its current bit.
- `out_bit`  out  1  stuffed serial bit, registered.
- `out_valid`  out  1  `out_bit` is valid, registered.
- `out_eop`  out  1  end-of-packet marker, registered, high for exactly 2 cycles per packet.
- `stuff_cnt`  out  8  number of stuffed bits in the current or last packet; saturates at 255.

## Operation
- The state machine has three states: IDLE, ACTIVE, EOP. A 1-bit `eop_cnt` sequences the two EOP cycles.
- `ones_cnt` is a registered count, 0..STUFF_LEN, of consecutive 1s emitted in the current packet.
- `pause` is combinational from registers only: `pause = (ones_cnt == STUFF_LEN) || (state == EOP)`. It has no path from `in_bit` or `in_sending`, so there is no combinational loop with the encoder.
- **IDLE**
  - If `in_sending` is high: register `out_bit <= in_bit` and `out_valid <= 1`. Set `ones_cnt` to `in_bit ? 1 : 0`, set `stuff_cnt <= 0`, and go to ACTIVE.
  - Otherwise: `out_valid <= 0`.
- **ACTIVE**, evaluated in this priority order:
  1. Stuff pending (`ones_cnt == STUFF_LEN`): `out_bit <= 0`, `out_valid <= 1`, `ones_cnt <= 0`, `stuff_cnt <= sat(stuff_cnt+1)`. `in_bit` and `in_sending` are ignored this cycle. The encoder is held by `pause`.
  2. Else if `in_sending` is high: `out_bit <= in_bit`, `out_valid <= 1`, and `ones_cnt <= in_bit ? ones_cnt+1 : 0`.
  3. Else (packet ended): `out_valid <= 0`, `out_eop <= 1`, `ones_cnt <= 0`, `eop_cnt <= 0`, and go to EOP.
- **EOP**
  - `out_valid` stays 0, and `pause` is high, which holds off any new encoder packet.
  - First EOP cycle: `out_eop` stays 1 and `eop_cnt <= 1`.
  - Second EOP cycle: `out_eop <= 0` and go to IDLE.
- A stuff triggered by the final payload bit is always emitted before EOP. Rule 1 outranks rule 3.
- `stuff_cnt` holds its value after the packet ends until the next packet starts.

## Timing
- Latency is 1 cycle: a bit accepted in cycle t appears on `out_bit`/`out_valid` in cycle t+1.
- The sixth consecutive 1 is accepted in cycle t. `pause` is high in cycle t+1, and the stuffed 0 is visible in cycle t+2. The encoder's held bit is accepted in cycle t+2 and appears in cycle t+3.
- `out_eop` goes high 1 cycle after the first cycle in ACTIVE with `in_sending` low and no stuff pending. It stays high for exactly 2 cycles.
- During a stuff and during EOP, `pause` is high for exactly 1 and exactly 2 cycles respectively.
- Reset values, applied asynchronously:
  - outputs: `out_bit` 0, `out_valid` 0, `out_eop` 0, `pause` 0, `stuff_cnt` 0;
  - internal: state IDLE, `ones_cnt` 0, `eop_cnt` 0.
- Reset in the middle of a packet or a stuff drops the packet. `pause` falls immediately, and no EOP is emitted.
- A 0 arriving on the cycle before `ones_cnt` would reach STUFF_LEN clears the count, and no stuff occurs.

## Structure
- Shared package `usb_pkg` holds:
  - the state enum `stuff_state_t` {IDLE, ACTIVE, EOP};
  - the default constant `USB_STUFF_LEN = 6`;
  - the width constant `STUFF_CNT_W = 8`.
- `ones_cnt` reuses the existing `counter` module with increment and clear controls. Its width is `$clog2(STUFF_LEN+1)`.
- Everything else is local: the FSM, the output registers, and the saturating `stuff_cnt`.

## Test plan
- **No ones.** Send 8 bits of 0x00 with `in_sending` high for 8 cycles.
  - Expect `out_bit` = 8 zeros, 1 cycle delayed, and `pause` never high.
  - Expect `out_eop` high for 2 cycles, then `stuff_cnt` = 0.
- **One stuff.** Send 7 ones.
  - Expect output 1111110 1, with `pause` high exactly 1 cycle after the sixth 1 is accepted.
  - Expect `stuff_cnt` = 1.
- **Two stuffs.** Send 12 ones.
  - Expect output 111111 0 111111 0 with 2 pause pulses, then EOP, and `stuff_cnt` = 2.
- **Count reset by a zero.** Send 11111 0 11111.
  - Expect no stuff, 11 output bits, and `stuff_cnt` = 0.
- **Stuff at packet end.** Send 6 ones, then drop `in_sending`.
  - Expect the stuffed 0 emitted before `out_eop` rises.
  - Expect `out_eop` 2 cycles, with `pause` high through both EOP cycles.
- **Reset mid-stuff.** Assert `rst_L` low while `pause` is high.
  - Expect `pause`, `out_valid` and `out_eop` to go to 0 asynchronously, and `stuff_cnt` = 0.
  - After release, expect the next packet to start cleanly from IDLE.
